muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle MIPS multiply/divide unit with HI/LO registers, beside the ALU in the execute stage.
//  Takes the same A (rs), B (rt) operand bus and funct field as the ALU; C is muxed with the ALU result.
//  Handles mult/multu/div/divu/mthi/mtlo/mfhi/mflo. The pipeline stalls on busy.
// PARAMETERS
//  MUL_CYCLES  4  busy cycles for mult/multu (legal range 1..16)
// PORTS
//  clk     in   1   rising-edge clock
//  rst_n   in   1   asynchronous, active-low reset
//  start   in   1   EX stage holds a muldiv-class instruction this cycle
//  cancel  in   1   abort the in-flight operation (exception/flush)
//  Op      in   6   funct field
//  A       in   32  rs operand (dividend / multiplicand / mthi-mtlo source)
//  B       in   32  rt operand (divisor / multiplier)
//  busy    out  1   operation in flight
//  HI      out  32  HI register
//  LO      out  32  LO register
//  C       out  32  mfhi -> HI, mflo -> LO, else 0; combinational from Op
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, HI=LO=0, all internal counters and regs 0; applies immediately, even mid-op.
//  Funct codes:
//   mult 011000, multu 011001, div 011010, divu 011011
//   mfhi 010000, mthi 010001, mflo 010010, mtlo 010011
//  Accept rule: start is sampled at posedge only when state=IDLE and cancel=0. Otherwise it is ignored;
//   the pipeline must stall and hold the instruction.
//  Operations on accept:
//   mthi/mtlo: HI/LO <= A at that edge; no busy.
//   mfhi/mflo: no state change.
//   Any other Op: no effect.
//  FSM states: IDLE, MUL, DIV_ITER, DIV_FIX.
//   IDLE -> MUL on accepted mult/multu: product computed (33-bit sign/zero-extend, signed 64-bit result),
//    held in regs, cnt=MUL_CYCLES. busy=1 for exactly MUL_CYCLES cycles.
//    {HI,LO} <= product on the edge where cnt 1->0, with state -> IDLE.
//   IDLE -> DIV_ITER on accepted div/divu: latch |A|, |B| (div) or A, B (divu) and both operand signs.
//    Restoring division, one quotient bit per cycle, 32 cycles.
//   DIV_ITER -> DIV_FIX after 32 iterations. In DIV_FIX, sign-correct, write LO=quotient, HI=remainder,
//    then -> IDLE. Total busy = 33 cycles.
//   Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
//   Divide by zero (div and divu): LO=32'hFFFFFFFF, HI=A. Still takes 33 cycles.
//   Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0.
//  busy = (state != IDLE). It rises the cycle after the accept edge and falls the cycle HI/LO show the result.
//  cancel=1 at a posedge with state!=IDLE: state -> IDLE, HI/LO unchanged, partial result discarded.
//  cancel and start in the same cycle: start ignored; cancel in IDLE has no effect.
//  C is valid only when busy=0; HI/LO never hold a partial result.
// TESTING
//  1. multu A=FFFFFFFF B=FFFFFFFF -> busy 4 cycles, then HI=FFFFFFFE LO=00000001.
//  2. mult A=FFFFFFFD(-3) B=7 -> HI=FFFFFFFF LO=FFFFFFEB; busy exactly MUL_CYCLES.
//  3. div A=FFFFFFF9(-7) B=2 -> busy 33 cycles, LO=FFFFFFFD HI=FFFFFFFF.
//     divu A=7 B=2 -> LO=3 HI=1.
//  4. div A=5 B=0 -> LO=FFFFFFFF HI=5. div A=80000000 B=FFFFFFFF -> LO=80000000 HI=0.
//  5. Cancel during div cycle 10 -> busy=0 next cycle, HI/LO keep prior values.
//     mult start asserted while busy -> ignored, HI/LO reflect only the first op.
//  6. mthi A=1234 -> HI=1234 next cycle; mfhi Op -> C=1234.
//     rst_n low mid-div -> busy=0, HI=LO=0 immediately.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operand/funct/result bundle between the execute stage and the multiply/divide unit
//  master (pipeline): drives start, cancel, Op (funct), A (rs), B (rt); reads busy, HI, LO, C
//  slave  (unit):     reads start, cancel, Op, A, B; drives busy, HI, LO, C
interface muldiv_unit_if;
    logic        start;
    logic        cancel;
    logic [5:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] C;
    modport master (output start, cancel, Op, A, B, input busy, HI, LO, C);
    modport slave  (input start, cancel, Op, A, B, output busy, HI, LO, C);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MIPS mult/multu/div/divu/mthi/mtlo/mfhi/mflo unit with HI/LO registers
//  clk   - rising-edge clock
//  rst_n - asynchronous active-low reset
//  bus   - slave side of muldiv_unit_if (start/cancel/Op/A/B in; busy/HI/LO/C out)
//  MUL_CYCLES - busy cycles for mult/multu (1..16)
module muldiv_unit #(
    parameter int MUL_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    muldiv_unit_if.slave   bus
);
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, MUL, DIV_ITER, DIV_FIX} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic        sgn_mul, sgn_div, neg_a, neg_b;
    logic [63:0] ext_a, ext_b, prod_full;
    logic [32:0] r_sh;
    logic        ge;

    assign accept  = bus.start && !bus.cancel;
    assign sgn_mul = bus.Op == F_MULT;
    assign sgn_div = bus.Op == F_DIV;
    // Lower 64 bits of the product of sign/zero-extended operands equal the signed 33x33 product
    assign ext_a     = {{32{sgn_mul & bus.A[31]}}, bus.A};
    assign ext_b     = {{32{sgn_mul & bus.B[31]}}, bus.B};
    assign prod_full = ext_a * ext_b;
    assign neg_a     = sgn_div & bus.A[31];
    assign neg_b     = sgn_div & bus.B[31];
    // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits
    assign r_sh = {rem_q, quo_q[31]};
    assign ge   = r_sh >= {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (accept) begin
                case (bus.Op)
                    F_MTHI: hi_d = bus.A;
                    F_MTLO: lo_d = bus.A;
                    F_MULT, F_MULTU: begin
                        prod_d  = prod_full;
                        cnt_d   = 6'(MUL_CYCLES);
                        state_d = MUL;
                    end
                    F_DIV, F_DIVU: begin
                        rem_d   = '0;
                        quo_d   = neg_a ? -bus.A : bus.A;
                        dvs_d   = neg_b ? -bus.B : bus.B;
                        negq_d  = neg_a ^ neg_b;
                        negr_d  = neg_a;
                        dz_d    = bus.B == '0;
                        cnt_d   = 6'd32;
                        state_d = DIV_ITER;
                    end
                    default: ;
                endcase
            end
            MUL: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    {hi_d, lo_d} = prod_q;
                    state_d      = IDLE;
                end
            end
            DIV_ITER: begin
                rem_d   = ge ? 32'(r_sh - {1'b0, dvs_q}) : r_sh[31:0];
                quo_d   = {quo_q[30:0], ge};
                cnt_d   = cnt_q - 6'd1;
                state_d = cnt_q == 6'd1 ? DIV_FIX : DIV_ITER;
            end
            DIV_FIX: begin
                // With a zero divisor the remainder already equals the dividend; only LO needs forcing
                lo_d    = dz_q ? 32'hFFFF_FFFF : negq_q ? -quo_q : quo_q;
                hi_d    = negr_q ? -rem_q : rem_q;
                state_d = IDLE;
            end
        endcase
        if (bus.cancel && state_q != IDLE) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = state_q != IDLE;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
    assign bus.C    = bus.Op == F_MFHI ? hi_q : bus.Op == F_MFLO ? lo_q : '0;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc;

    muldiv_unit_if bus ();
    muldiv_unit #(.MUL_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.Op    = 6'b000000;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        issue(op, a, b);
        wait_idle(n);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.Op     = 6'b000000;
        bus.A      = '0;
        bus.B      = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);

        run(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        chk("multu_cycles", 32'(cyc), 32'd4);
        chk("multu_hi", bus.HI, 32'hFFFF_FFFE);
        chk("multu_lo", bus.LO, 32'h0000_0001);

        run(F_MULT, 32'hFFFF_FFFD, 32'd7, cyc);
        chk("mult_cycles", 32'(cyc), 32'd4);
        chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo", bus.LO, 32'hFFFF_FFEB);

        run(F_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
        chk("div_cycles", 32'(cyc), 32'd33);
        chk("div_lo", bus.LO, 32'hFFFF_FFFD);
        chk("div_hi", bus.HI, 32'hFFFF_FFFF);

        run(F_DIVU, 32'd7, 32'd2, cyc);
        chk("divu_lo", bus.LO, 32'd3);
        chk("divu_hi", bus.HI, 32'd1);

        run(F_DIV, 32'd5, 32'd0, cyc);
        chk("div0_cycles", 32'(cyc), 32'd33);
        chk("div0_lo", bus.LO, 32'hFFFF_FFFF);
        chk("div0_hi", bus.HI, 32'd5);

        run(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        chk("ovf_lo", bus.LO, 32'h8000_0000);
        chk("ovf_hi", bus.HI, 32'd0);

        run(F_DIVU, 32'hFFFF_FFF0, 32'd0, cyc);
        chk("divu0_lo", bus.LO, 32'hFFFF_FFFF);
        chk("divu0_hi", bus.HI, 32'hFFFF_FFF0);

        run(F_DIV, 32'd7, 32'hFFFF_FFFE, cyc);
        chk("divnb_lo", bus.LO, 32'hFFFF_FFFD);
        chk("divnb_hi", bus.HI, 32'd1);

        issue(F_DIV, 32'd100, 32'd3);
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        chk("cancel_busy", 32'(bus.busy), 32'd0);
        chk("cancel_hi", bus.HI, 32'd1);
        chk("cancel_lo", bus.LO, 32'hFFFF_FFFD);
        repeat (40) @(negedge clk);
        chk("cancel_hold_lo", bus.LO, 32'hFFFF_FFFD);

        issue(F_MULTU, 32'd3, 32'd5);
        bus.start = 1'b1;
        bus.Op    = F_MULT;
        bus.A     = 32'd100;
        bus.B     = 32'd100;
        @(negedge clk);
        bus.start = 1'b0;
        bus.Op    = 6'b000000;
        wait_idle(cyc);
        chk("ign_cycles", 32'(cyc), 32'd3);
        @(negedge clk);
        chk("ign_busy", 32'(bus.busy), 32'd0);
        chk("ign_hi", bus.HI, 32'd0);
        chk("ign_lo", bus.LO, 32'd15);

        bus.cancel = 1'b1;
        issue(F_MULTU, 32'd9, 32'd9);
        bus.cancel = 1'b0;
        chk("startcancel_busy", 32'(bus.busy), 32'd0);
        chk("startcancel_lo", bus.LO, 32'd15);

        issue(F_MTHI, 32'h0000_1234, 32'd0);
        chk("mthi_hi", bus.HI, 32'h0000_1234);
        chk("mthi_busy", 32'(bus.busy), 32'd0);
        issue(F_MTLO, 32'hCAFE_0001, 32'd0);
        chk("mtlo_lo", bus.LO, 32'hCAFE_0001);
        chk("mtlo_hi_kept", bus.HI, 32'h0000_1234);
        bus.Op = F_MFHI;
        #1 chk("mfhi_c", bus.C, 32'h0000_1234);
        bus.Op = F_MFLO;
        #1 chk("mflo_c", bus.C, 32'hCAFE_0001);
        bus.Op = F_DIVU;
        #1 chk("other_c", bus.C, 32'd0);
        bus.Op = 6'b000000;

        issue(F_DIV, 32'd100, 32'd3);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("amid_rst_busy", 32'(bus.busy), 32'd0);
        chk("amid_rst_hi", bus.HI, 32'd0);
        chk("amid_rst_lo", bus.LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_lo", bus.LO, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
